// File: rtl/axis_traffic_pkg.sv
// Shared definitions for the AXIS traffic tile: tdata field layout, generator states, LFSR helpers.
// The optional LFSR payload is enabled with `define AXIS_TRAFFIC_TILE_LFSR_EN.
package axis_traffic_pkg;

  localparam int BeatLsb   = 0;
  localparam int SeqLsb    = 16;
  localparam int LfsrLsb   = 32;
  localparam int BeatWidth = 16;
  localparam int SeqWidth  = 16;
  localparam int LfsrWidth = 32;

  localparam logic [LfsrWidth-1:0] LfsrPoly = 32'h8020_0003;

  typedef enum logic {
    IDLE,
    SEND
  } gen_state_e;

  function automatic logic [LfsrWidth-1:0] lfsr_seed(input int unsigned idx);
    return LfsrWidth'(idx + 1);
  endfunction

  // Galois form, shifting towards the LSB; the bit shifted out selects the feedback taps.
  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] cur);
    return cur[0] ? ((cur >> 1) ^ LfsrPoly) : (cur >> 1);
  endfunction

endpackage

// File: rtl/axis_traffic_checker.sv
// AXIS target side of the traffic tile: per-stream sequence/beat tracking, sticky error flags
// and received-packet counter. LFSR payload checking is enabled with AXIS_TRAFFIC_TILE_LFSR_EN.
module axis_traffic_checker
  import axis_traffic_pkg::*;
#(
  parameter int TDataWidth  = 64,
  parameter int TIdWidth    = 4,
  parameter int NumStreams  = 4,
  parameter int PktLenWidth = 8,
  parameter int CntWidth    = 32
) (
  input  logic                   clk_axis_i,
  input  logic                   rst_axis_i,
  input  logic [PktLenWidth-1:0] pkt_len_i,
  input  logic                   rx_ready_i,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDataWidth-1:0]  s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [TIdWidth-1:0]    s_axis_tid,
  output logic [CntWidth-1:0]    rx_pkt_cnt_o,
  output logic                   err_seq_o,
  output logic                   err_len_o,
  output logic                   err_tid_o
);

  localparam int IdxWidth = (NumStreams > 1) ? $clog2(NumStreams) : 1;

  logic                 tready_q, tready_d;
  logic [BeatWidth-1:0] exp_beat_q [NumStreams];
  logic [BeatWidth-1:0] exp_beat_d [NumStreams];
  logic [SeqWidth-1:0]  exp_seq_q  [NumStreams];
  logic [SeqWidth-1:0]  exp_seq_d  [NumStreams];
  logic [CntWidth-1:0]  rx_cnt_q, rx_cnt_d;
  logic                 err_seq_q, err_seq_d;
  logic                 err_len_q, err_len_d;
  logic                 err_tid_q, err_tid_d;

  logic                 rx_hs;
  logic                 tid_ok;
  logic [IdxWidth-1:0]  idx;
  logic [BeatWidth-1:0] rx_beat;
  logic [SeqWidth-1:0]  rx_seq;
  logic [BeatWidth-1:0] len_m1;
  logic                 exp_last;

`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
  logic [LfsrWidth-1:0] mirror_q [NumStreams];
  logic [LfsrWidth-1:0] mirror_d [NumStreams];
  logic                 pkt_bad_q [NumStreams];
  logic                 pkt_bad_d [NumStreams];
  logic [LfsrWidth-1:0] rx_lfsr;
  logic [LfsrWidth-1:0] exp_lfsr;
  logic                 lfsr_bad;
`endif

  assign rx_hs   = s_axis_tvalid & tready_q;
  assign tid_ok  = {1'b0, s_axis_tid} < (TIdWidth + 1)'(NumStreams);
  assign idx     = s_axis_tid[IdxWidth-1:0];
  assign rx_beat = s_axis_tdata[BeatLsb +: BeatWidth];
  assign rx_seq  = s_axis_tdata[SeqLsb +: SeqWidth];
  assign len_m1  = (pkt_len_i == '0) ? '0 : BeatWidth'(pkt_len_i) - BeatWidth'(1);
  assign exp_last = (exp_beat_q[idx] == len_m1);

  always_comb begin
    tready_d   = rx_ready_i;
    exp_beat_d = exp_beat_q;
    exp_seq_d  = exp_seq_q;
    rx_cnt_d   = rx_cnt_q;
    err_seq_d  = err_seq_q;
    err_len_d  = err_len_q;
    err_tid_d  = err_tid_q;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
    mirror_d   = mirror_q;
    pkt_bad_d  = pkt_bad_q;
    rx_lfsr    = LfsrWidth'(s_axis_tdata >> LfsrLsb);
    // Only the LFSR bits that actually fit in tdata are compared.
    exp_lfsr   = LfsrWidth'((TDataWidth'(mirror_q[idx]) << LfsrLsb) >> LfsrLsb);
    lfsr_bad   = (rx_lfsr != exp_lfsr);
`endif

    if (rx_hs) begin
      if (!tid_ok) begin
        err_tid_d = 1'b1;
      end else begin
        if ((exp_beat_q[idx] == '0) && (rx_seq != exp_seq_q[idx])) err_seq_d = 1'b1;
        if (rx_beat != exp_beat_q[idx]) err_len_d = 1'b1;
        if (s_axis_tlast != exp_last) err_len_d = 1'b1;

        if (s_axis_tlast) begin
          exp_beat_d[idx] = '0;
          exp_seq_d[idx]  = rx_seq + SeqWidth'(1);
          rx_cnt_d        = rx_cnt_q + CntWidth'(1);
        end else begin
          exp_beat_d[idx] = exp_beat_q[idx] + BeatWidth'(1);
        end

`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
        if (lfsr_bad) err_seq_d = 1'b1;
        if (s_axis_tlast) begin
          pkt_bad_d[idx] = 1'b0;
          mirror_d[idx]  = (pkt_bad_q[idx] || lfsr_bad) ? lfsr_next(rx_lfsr)
                                                        : lfsr_next(mirror_q[idx]);
        end else begin
          pkt_bad_d[idx] = pkt_bad_q[idx] | lfsr_bad;
          mirror_d[idx]  = lfsr_next(mirror_q[idx]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      tready_q  <= 1'b0;
      rx_cnt_q  <= '0;
      err_seq_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tid_q <= 1'b0;
      for (int i = 0; i < NumStreams; i++) begin
        exp_beat_q[i] <= '0;
        exp_seq_q[i]  <= '0;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
        mirror_q[i]   <= lfsr_seed(i);
        pkt_bad_q[i]  <= 1'b0;
`endif
      end
    end else begin
      tready_q   <= tready_d;
      rx_cnt_q   <= rx_cnt_d;
      err_seq_q  <= err_seq_d;
      err_len_q  <= err_len_d;
      err_tid_q  <= err_tid_d;
      exp_beat_q <= exp_beat_d;
      exp_seq_q  <= exp_seq_d;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
      mirror_q   <= mirror_d;
      pkt_bad_q  <= pkt_bad_d;
`endif
    end
  end

  assign s_axis_tready = tready_q;
  assign rx_pkt_cnt_o  = rx_cnt_q;
  assign err_seq_o     = err_seq_q;
  assign err_len_o     = err_len_q;
  assign err_tid_o     = err_tid_q;

endmodule

// File: rtl/axis_traffic_tile.sv
// AXIS traffic tile: round-robin multi-stream packet generator plus the stream checker.
// Define AXIS_TRAFFIC_TILE_LFSR_EN to carry and check a per-stream LFSR in tdata[TDataWidth-1:32].
module axis_traffic_tile
  import axis_traffic_pkg::*;
#(
  parameter int TDataWidth  = 64,
  parameter int TIdWidth    = 4,
  parameter int TDestWidth  = 4,
  parameter int NumStreams  = 4,
  parameter int PktLenWidth = 8,
  parameter int CntWidth    = 32
) (
  input  logic                             clk_axis_i,
  input  logic                             rst_axis_i,
  input  logic                             gen_enable_i,
  input  logic [PktLenWidth-1:0]           pkt_len_i,
  input  logic [NumStreams*TDestWidth-1:0] dest_i,
  input  logic                             rx_ready_i,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [TDataWidth-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [TIdWidth-1:0]              m_axis_tid,
  output logic [TDestWidth-1:0]            m_axis_tdest,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [TDataWidth-1:0]            s_axis_tdata,
  input  logic                             s_axis_tlast,
  input  logic [TIdWidth-1:0]              s_axis_tid,
  input  logic [TDestWidth-1:0]            s_axis_tdest,
  output logic [CntWidth-1:0]              tx_pkt_cnt_o,
  output logic [CntWidth-1:0]              rx_pkt_cnt_o,
  output logic                             err_seq_o,
  output logic                             err_len_o,
  output logic                             err_tid_o
);

  localparam int IdxWidth = (NumStreams > 1) ? $clog2(NumStreams) : 1;

  gen_state_e             state_q, state_d;
  logic [IdxWidth-1:0]    stream_q, stream_d;
  logic [IdxWidth-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PktLenWidth-1:0] beat_q, beat_d;
  logic [SeqWidth-1:0]    seq_q [NumStreams];
  logic [SeqWidth-1:0]    seq_d [NumStreams];
  logic [CntWidth-1:0]    tx_cnt_q, tx_cnt_d;
  logic [PktLenWidth-1:0] len_m1;
  logic                   tx_last;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
  logic [LfsrWidth-1:0]   lfsr_q [NumStreams];
  logic [LfsrWidth-1:0]   lfsr_d [NumStreams];
`endif

  assign len_m1  = (pkt_len_i == '0) ? '0 : pkt_len_i - PktLenWidth'(1);
  assign tx_last = (beat_q == len_m1);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    stream_d = stream_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    seq_d    = seq_q;
    tx_cnt_d = tx_cnt_q;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
    lfsr_d   = lfsr_q;
`endif
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;

    unique case (state_q)
      IDLE: begin
        if (gen_enable_i) begin
          stream_d = rr_ptr_q;
          beat_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        // Payload depends only on registered state, so it holds until the handshake.
        m_axis_tvalid = 1'b1;
        m_axis_tid    = TIdWidth'(stream_q);
        m_axis_tdest  = dest_i[int'(stream_q)*TDestWidth +: TDestWidth];
        m_axis_tlast  = tx_last;
        m_axis_tdata[BeatLsb +: BeatWidth] = BeatWidth'(beat_q);
        m_axis_tdata[SeqLsb +: SeqWidth]   = seq_q[stream_q];
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
        m_axis_tdata = m_axis_tdata | (TDataWidth'(lfsr_q[stream_q]) << LfsrLsb);
`endif
        if (m_axis_tready) begin
          beat_d = beat_q + PktLenWidth'(1);
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
          lfsr_d[stream_q] = lfsr_next(lfsr_q[stream_q]);
`endif
          if (tx_last) begin
            seq_d[stream_q] = seq_q[stream_q] + SeqWidth'(1);
            rr_ptr_d = (rr_ptr_q == IdxWidth'(NumStreams - 1)) ? '0 : rr_ptr_q + IdxWidth'(1);
            tx_cnt_d = tx_cnt_q + CntWidth'(1);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      state_q  <= IDLE;
      stream_q <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      tx_cnt_q <= '0;
      // NOTE: the per-stream arrays are small register files whose cleared state is
      // architecturally visible (seq restarts at 0), so they are reset, unlike a RAM.
      for (int i = 0; i < NumStreams; i++) begin
        seq_q[i]  <= '0;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
        lfsr_q[i] <= lfsr_seed(i);
`endif
      end
    end else begin
      state_q  <= state_d;
      stream_q <= stream_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      tx_cnt_q <= tx_cnt_d;
      seq_q    <= seq_d;
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign tx_pkt_cnt_o = tx_cnt_q;

  // tdest is routing information only; the checker does not inspect it.
  axis_traffic_checker #(
    .TDataWidth (TDataWidth),
    .TIdWidth   (TIdWidth),
    .NumStreams (NumStreams),
    .PktLenWidth(PktLenWidth),
    .CntWidth   (CntWidth)
  ) u_checker (
    .clk_axis_i   (clk_axis_i),
    .rst_axis_i   (rst_axis_i),
    .pkt_len_i    (pkt_len_i),
    .rx_ready_i   (rx_ready_i),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tid   (s_axis_tid),
    .rx_pkt_cnt_o (rx_pkt_cnt_o),
    .err_seq_o    (err_seq_o),
    .err_len_o    (err_len_o),
    .err_tid_o    (err_tid_o)
  );

endmodule

// File: tb/tb_axis_traffic_tile.sv
// Scoreboard bench for axis_traffic_tile: loopback traffic against a packet-level model,
// plus direct injection of faulty packets into the checker.
module tb_axis_traffic_tile;

  localparam int TDataWidth  = 64;
  localparam int TIdWidth    = 4;
  localparam int TDestWidth  = 4;
  localparam int NumStreams  = 4;
  localparam int PktLenWidth = 8;
  localparam int CntWidth    = 32;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic                             gen_en = 1'b0;
  logic [PktLenWidth-1:0]           pkt_len = 8'd4;
  logic [NumStreams*TDestWidth-1:0] dest_bus;
  logic                             rx_ready = 1'b1;
  logic                             m_tvalid, m_tready, m_tlast;
  logic [TDataWidth-1:0]            m_tdata;
  logic [TIdWidth-1:0]              m_tid;
  logic [TDestWidth-1:0]            m_tdest;
  logic                             s_tvalid, s_tready, s_tlast;
  logic [TDataWidth-1:0]            s_tdata;
  logic [TIdWidth-1:0]              s_tid;
  logic [TDestWidth-1:0]            s_tdest;
  logic [CntWidth-1:0]              tx_cnt, rx_cnt;
  logic                             err_seq, err_len, err_tid;

  logic                  loop_en = 1'b1;
  logic                  inj_valid = 1'b0;
  logic [TDataWidth-1:0] inj_data = '0;
  logic                  inj_last = 1'b0;
  logic [TIdWidth-1:0]   inj_tid = '0;
  logic [TDestWidth-1:0] dest_cfg [NumStreams];

  for (genvar g = 0; g < NumStreams; g++) begin : g_dest
    assign dest_bus[g*TDestWidth +: TDestWidth] = dest_cfg[g];
  end

  assign s_tvalid = loop_en ? m_tvalid : inj_valid;
  assign s_tdata  = loop_en ? m_tdata  : inj_data;
  assign s_tlast  = loop_en ? m_tlast  : inj_last;
  assign s_tid    = loop_en ? m_tid    : inj_tid;
  assign s_tdest  = loop_en ? m_tdest  : '0;
  assign m_tready = loop_en ? s_tready : 1'b0;

  always #5 clk = ~clk;

  axis_traffic_tile #(
    .TDataWidth(TDataWidth), .TIdWidth(TIdWidth), .TDestWidth(TDestWidth),
    .NumStreams(NumStreams), .PktLenWidth(PktLenWidth), .CntWidth(CntWidth)
  ) dut (
    .clk_axis_i   (clk),
    .rst_axis_i   (rst),
    .gen_enable_i (gen_en),
    .pkt_len_i    (pkt_len),
    .dest_i       (dest_bus),
    .rx_ready_i   (rx_ready),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast),
    .m_axis_tid   (m_tid),
    .m_axis_tdest (m_tdest),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .s_axis_tid   (s_tid),
    .s_axis_tdest (s_tdest),
    .tx_pkt_cnt_o (tx_cnt),
    .rx_pkt_cnt_o (rx_cnt),
    .err_seq_o    (err_seq),
    .err_len_o    (err_len),
    .err_tid_o    (err_tid)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level reference model: round-robin streams, per-stream 16-bit sequence numbers.
  typedef struct {
    logic [TIdWidth-1:0]   tid;
    logic [TDestWidth-1:0] tdest;
    logic                  last;
    logic [TDataWidth-1:0] data;
  } beat_t;

  beat_t       exp_q [$];
  int          ref_rr;
  int          ref_seq  [NumStreams];
  logic [31:0] ref_lfsr [NumStreams];
  int          exp_tx, exp_rx;

  function automatic logic [127:0] pack(input beat_t b);
    return 128'({b.tid, b.tdest, b.last, b.data});
  endfunction

  task automatic model_reset();
    ref_rr = 0;
    exp_tx = 0;
    exp_rx = 0;
    exp_q.delete();
    for (int i = 0; i < NumStreams; i++) begin
      ref_seq[i]  = 0;
      ref_lfsr[i] = 32'(i + 1);
    end
  endtask

  task automatic model_push_pkt(input int len_cfg);
    int    len;
    int    s;
    beat_t x;
    len = (len_cfg == 0) ? 1 : len_cfg;
    s   = ref_rr;
    for (int b = 0; b < len; b++) begin
      x.tid   = TIdWidth'(s);
      x.tdest = dest_cfg[s];
      x.last  = (b == len - 1);
`ifdef AXIS_TRAFFIC_TILE_LFSR_EN
      x.data  = {ref_lfsr[s], ref_seq[s][15:0], b[15:0]};
      ref_lfsr[s] = (ref_lfsr[s] >> 1) ^ (ref_lfsr[s][0] ? 32'h8020_0003 : 32'h0);
`else
      x.data  = {32'h0, ref_seq[s][15:0], b[15:0]};
`endif
      exp_q.push_back(x);
    end
    ref_seq[s] = (ref_seq[s] + 1) % 65536;
    ref_rr     = (ref_rr + 1) % NumStreams;
    exp_tx++;
    exp_rx++;
  endtask

  // Monitor: pops the scoreboard on every m_axis handshake and checks the AXIS hold rule.
  logic  held = 1'b0;
  beat_t held_b;
  beat_t cur_b;
  always @(negedge clk) begin
    cur_b.tid   = m_tid;
    cur_b.tdest = m_tdest;
    cur_b.last  = m_tlast;
    cur_b.data  = m_tdata;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 128'(m_tvalid), 128'(1));
        check("hold_payload", pack(cur_b), pack(held_b));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none", pack(cur_b));
        end else begin
          check("beat", pack(cur_b), pack(exp_q.pop_front()));
        end
      end
      held   = m_tvalid && !m_tready;
      held_b = cur_b;
    end
  end

  task automatic check_flags(input string tag, input logic s, input logic l, input logic t);
    check({tag, "_err_seq"}, 128'(err_seq), 128'(s));
    check({tag, "_err_len"}, 128'(err_len), 128'(l));
    check({tag, "_err_tid"}, 128'(err_tid), 128'(t));
  endtask

  // mode 0: ready always high, 1: toggle every 3 cycles, 2: random ready.
  task automatic run_packets(input int n, input int len, input int mode, input string tag);
    int   starts = 0;
    logic prev = 1'b0;
    logic done = 1'b0;
    pkt_len = PktLenWidth'(len);
    for (int i = 0; i < n; i++) model_push_pkt(len);
    gen_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (mode == 1) rx_ready = ((cyc / 3) % 2) == 0;
      else if (mode == 2) rx_ready = 1'($urandom_range(0, 1));
      if (m_tvalid && !prev) starts++;
      prev = m_tvalid;
      if (starts >= n) gen_en = 1'b0;
      if (tx_cnt == CntWidth'(exp_tx) && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    gen_en   = 1'b0;
    rx_ready = 1'b1;
    check({tag, "_finished"}, 128'(done), 128'(1));
    check({tag, "_tx_cnt"}, 128'(tx_cnt), 128'(exp_tx));
    check({tag, "_rx_cnt"}, 128'(rx_cnt), 128'(exp_rx));
    check_flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_beat(input int tid, input int seq, input int beat, input logic last);
    logic ok = 1'b0;
    inj_tid   = TIdWidth'(tid);
    inj_data  = {32'h0, seq[15:0], beat[15:0]};
    inj_last  = last;
    inj_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    inj_valid = 1'b0;
    check("inject_accepted", 128'(ok), 128'(1));
  endtask

  task automatic send_pkt(input int tid, input int seq, input int nbeats, input int last_at);
    for (int b = 0; b < nbeats; b++) send_beat(tid, seq, b, b == last_at);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < NumStreams; i++) dest_cfg[i] = TDestWidth'($urandom);
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_m_tdata", 128'(m_tdata), 128'(0));
    check("rst_m_tid", 128'(m_tid), 128'(0));
    check("rst_s_tready", 128'(s_tready), 128'(0));
    check("rst_tx_cnt", 128'(tx_cnt), 128'(0));
    check("rst_rx_cnt", 128'(rx_cnt), 128'(0));
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    run_packets(8, 4, 0, "loop8");
    run_packets(6, 4, 1, "toggle");
    run_packets(5, 3, 2, "random");
    run_packets(4, 0, 2, "len0");
    run_packets(3, 1, 1, "len1");

    // Reset while beat 1 of a packet is being accepted.
    pkt_len = 8'd4;
    model_push_pkt(4);
    gen_en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready && m_tdata[15:0] == 16'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_reached_beat1", 128'(found), 128'(1));
    rst    = 1'b1;
    gen_en = 1'b0;
    @(negedge clk);
    check("midrst_m_tvalid", 128'(m_tvalid), 128'(0));
    check("midrst_tx_cnt", 128'(tx_cnt), 128'(0));
    check("midrst_rx_cnt", 128'(rx_cnt), 128'(0));
    check_flags("midrst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    run_packets(1, 4, 0, "after_rst");

    // Direct injection into the checker.
    loop_en = 1'b0;
    pkt_len = 8'd4;
    do_reset();
    send_pkt(1, 0, 4, 3);
    check("inj_good_rx", 128'(rx_cnt), 128'(1));
    check_flags("inj_good", 1'b0, 1'b0, 1'b0);
    send_pkt(2, 5, 4, 3);
    check("inj_seq_rx", 128'(rx_cnt), 128'(2));
    check_flags("inj_seq", 1'b1, 1'b0, 1'b0);
    send_pkt(2, 6, 4, 3);
    check("inj_resync_rx", 128'(rx_cnt), 128'(3));
    check_flags("inj_resync", 1'b1, 1'b0, 1'b0);

    do_reset();
    send_pkt(0, 0, 3, 2);
    check("inj_early_last_rx", 128'(rx_cnt), 128'(1));
    check_flags("inj_early_last", 1'b0, 1'b1, 1'b0);
    send_pkt(0, 1, 4, 3);
    check("inj_after_len_rx", 128'(rx_cnt), 128'(2));
    check_flags("inj_after_len", 1'b0, 1'b1, 1'b0);

    do_reset();
    send_beat(7, 0, 0, 1'b1);
    check("inj_bad_tid_rx", 128'(rx_cnt), 128'(0));
    check_flags("inj_bad_tid", 1'b0, 1'b0, 1'b1);

    do_reset();
    for (int b = 0; b < 4; b++) begin
      send_beat(0, 0, b, b == 3);
      send_beat(3, 0, b, b == 3);
    end
    check("inj_interleave_rx", 128'(rx_cnt), 128'(2));
    check_flags("inj_interleave", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
